// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and FSM states.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_fa4.sv
// FullAdder4: combinational 4-bit carry-lookahead adder used once per nibble.
module nibble_serial_adder_fa4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_carry,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_carry
);

    logic [NIBBLE_W-1:0] w_gen;
    logic [NIBBLE_W-1:0] w_prop;
    logic [NIBBLE_W:0]   w_c;

    assign w_gen  = i_a & i_b;
    assign w_prop = i_a ^ i_b;

    // Every carry is expanded from i_carry directly so no carry waits on another.
    assign w_c[0] = i_carry;
    assign w_c[1] = w_gen[0] | (w_prop[0] & i_carry);
    assign w_c[2] = w_gen[1] | (w_prop[1] & w_gen[0])
                  | (w_prop[1] & w_prop[0] & i_carry);
    assign w_c[3] = w_gen[2] | (w_prop[2] & w_gen[1])
                  | (w_prop[2] & w_prop[1] & w_gen[0])
                  | (w_prop[2] & w_prop[1] & w_prop[0] & i_carry);
    assign w_c[4] = w_gen[3] | (w_prop[3] & w_gen[2])
                  | (w_prop[3] & w_prop[2] & w_gen[1])
                  | (w_prop[3] & w_prop[2] & w_prop[1] & w_gen[0])
                  | (w_prop[3] & w_prop[2] & w_prop[1] & w_prop[0] & i_carry);

    assign o_sum   = w_prop ^ w_c[NIBBLE_W-1:0];
    assign o_carry = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract that streams one nibble per cycle through a
// single 4-bit carry-lookahead adder, with valid/ready handshakes on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    generate
        if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_badWidth
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t               r_state;
    state_t               w_stateNext;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [WIDTH-1:0]     r_result;
    logic                 r_carryOut;
    logic                 r_overflow;
    logic                 r_zero;
    logic                 r_outValid;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_release;
    logic [WIDTH-1:0]     w_aShift;
    logic [WIDTH-1:0]     w_bShift;
    logic [NIBBLE_W-1:0]  w_sumNib;
    logic                 w_faCarry;
    logic [WIDTH-1:0]     w_resultNext;

    // Nibble select: shift the captured operands down to the current nibble.
    assign w_aShift = r_a >> {r_cnt, 2'b00};
    assign w_bShift = r_b >> {r_cnt, 2'b00};

    nibble_serial_adder_fa4 u_FullAdder4 (
        .i_a     (w_aShift[NIBBLE_W-1:0]),
        .i_b     (w_bShift[NIBBLE_W-1:0]),
        .i_carry (r_carry),
        .o_sum   (w_sumNib),
        .o_carry (w_faCarry)
    );

    always_comb begin
        w_resultNext = r_result;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_resultNext[i*NIBBLE_W +: NIBBLE_W] = w_sumNib;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_release   = 1'b0;
        InReady     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                InReady  = 1'b1;
                w_accept = InValid;
                if (InValid) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                w_last = (r_cnt == LAST_CNT);
                if (r_cnt == LAST_CNT) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                w_release = OutReady;
                if (OutReady) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Subtraction is folded into the add: A + ~B + ~borrow.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_result   <= '0;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_outValid <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= CarryIn ^ Sub;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_result <= w_resultNext;
            r_carry  <= w_faCarry;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_carryOut <= w_faCarry;
                r_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                              (w_sumNib[NIBBLE_W-1] != r_a[WIDTH-1]);
                r_zero     <= (w_resultNext == '0);
                r_outValid <= 1'b1;
            end
        end else if (w_release) begin
            r_outValid <= 1'b0;
        end
    end

    assign OutValid = r_outValid;
    assign Result   = r_result;
    assign CarryOut = r_carryOut;
    assign Overflow = r_overflow;
    assign Zero     = r_zero;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: randomized and directed operations on a WIDTH=16 adder
// against an arithmetic reference model, plus a WIDTH=4 instance.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] result;
    logic         carryOut;
    logic         overflow;
    logic         zero;

    logic         inValid4;
    logic         inReady4;
    logic [3:0]   a4;
    logic [3:0]   b4;
    logic         outValid4;
    logic         outReady4;
    logic [3:0]   result4;
    logic         carryOut4;
    logic         overflow4;
    logic         zero4;

    int checks = 0;
    int passes = 0;
    int opsDone = 0;

    int   mCount = 0;
    bit   mValid = 1'b0;
    bit   mFresh = 1'b1;
    exp_t mExp   = '0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .Clk      (clk),
        .ResetN   (rst_n),
        .InValid  (inValid),
        .InReady  (inReady),
        .A        (a),
        .B        (b),
        .CarryIn  (cin),
        .Sub      (sub),
        .OutValid (outValid),
        .OutReady (outReady),
        .Result   (result),
        .CarryOut (carryOut),
        .Overflow (overflow),
        .Zero     (zero)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .Clk      (clk),
        .ResetN   (rst_n),
        .InValid  (inValid4),
        .InReady  (inReady4),
        .A        (a4),
        .B        (b4),
        .CarryIn  (1'b0),
        .Sub      (1'b0),
        .OutValid (outValid4),
        .OutReady (outReady4),
        .Result   (result4),
        .CarryOut (carryOut4),
        .Overflow (overflow4),
        .Zero     (zero4)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the true signed/unsigned values.
    function automatic exp_t modelOp(input logic [W-1:0] av, input logic [W-1:0] bv,
                                     input logic c, input logic s);
        longint ua, ub, sa, sb, cc, u, exact;
        exp_t r;
        ua = longint'(av);
        ub = longint'(bv);
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        cc = c ? 64'sd1 : 64'sd0;
        u     = s ? (ua - ub - cc) : (ua + ub + cc);
        exact = s ? (sa - sb - cc) : (sa + sb + cc);
        r.res   = u[W-1:0];
        r.carry = s ? (u >= 0) : (u >= (longint'(1) << W));
        r.ovf   = (exact > ((longint'(1) << (W-1)) - 1)) || (exact < -(longint'(1) << (W-1)));
        r.zero  = (r.res == '0);
        return r;
    endfunction

    // Transaction timing model: busy for NIB edges after accept, then holds until taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCount <= 0;
            mValid <= 1'b0;
            mFresh <= 1'b1;
        end else if (mCount > 0) begin
            mCount <= mCount - 1;
            if (mCount == 1) begin
                mValid <= 1'b1;
            end
        end else if (mValid) begin
            if (outReady) begin
                mValid <= 1'b0;
            end
        end else if (inValid) begin
            mCount <= NIB;
            mFresh <= 1'b0;
            mExp   <= modelOp(a, b, cin, sub);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("InReady", {31'd0, inReady}, {31'd0, (mCount == 0) && !mValid});
            checkOutput("OutValid", {31'd0, outValid}, {31'd0, mValid});
            if (mValid) begin
                checkOutput("Result", {16'd0, result}, {16'd0, mExp.res});
                checkOutput("CarryOut", {31'd0, carryOut}, {31'd0, mExp.carry});
                checkOutput("Overflow", {31'd0, overflow}, {31'd0, mExp.ovf});
                checkOutput("Zero", {31'd0, zero}, {31'd0, mExp.zero});
                if (outReady) begin
                    opsDone++;
                end
            end else if (mFresh) begin
                checkOutput("Result after reset", {16'd0, result}, 32'd0);
                checkOutput("flags after reset", {29'd0, carryOut, overflow, zero}, 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic c, input logic s);
        int n = 0;
        while (!inReady && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!inReady) begin
            checkOutput("InReady wait timeout", 32'd0, 32'd1);
        end
        a = av;
        b = bv;
        cin = c;
        sub = s;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (!outValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic directedOp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic c, input logic s, input logic [W-1:0] er,
                              input logic ec, input logic eo, input logic ez, input int hold);
        int lat;
        outReady = 1'b0;
        applyStimulus(av, bv, c, s);
        waitValid(lat);
        checkOutput({tag, " latency"}, lat, NIB);
        for (int k = 0; k <= hold; k++) begin
            checkOutput({tag, " result"}, {16'd0, result}, {16'd0, er});
            checkOutput({tag, " carry/ovf/zero"}, {29'd0, carryOut, overflow, zero},
                        {29'd0, ec, eo, ez});
            if (k < hold) begin
                checkOutput({tag, " InReady in DONE"}, {31'd0, inReady}, 32'd0);
                a = W'($urandom);
                b = W'($urandom);
                inValid = 1'b1;
                @(posedge clk); #1;
                inValid = 1'b0;
            end
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput({tag, " OutValid after take"}, {31'd0, outValid}, 32'd0);
        checkOutput({tag, " InReady after take"}, {31'd0, inReady}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        inValid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        outReady = 1'b0;
        inValid4 = 1'b0;
        a4 = '0;
        b4 = '0;
        outReady4 = 1'b1;

        checkOutput("model 0x1234+0x4321", modelOp(16'h1234, 16'h4321, 1'b0, 1'b0), {16'h5555, 3'b000});
        checkOutput("model 0xFFFF+1", modelOp(16'hFFFF, 16'h0001, 1'b0, 1'b0), {16'h0000, 3'b101});
        checkOutput("model 0x7FFF+1", modelOp(16'h7FFF, 16'h0001, 1'b0, 1'b0), {16'h8000, 3'b010});
        checkOutput("model 5-7", modelOp(16'h0005, 16'h0007, 1'b0, 1'b1), {16'hFFFE, 3'b000});
        checkOutput("model 8000-1", modelOp(16'h8000, 16'h0001, 1'b0, 1'b1), {16'h7FFF, 3'b110});

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset InReady", {31'd0, inReady}, 32'd1);
        checkOutput("reset OutValid", {31'd0, outValid}, 32'd0);
        checkOutput("reset Result", {16'd0, result}, 32'd0);

        $display("[TB] directed operations");
        directedOp("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 5);
        directedOp("add FFFF+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        directedOp("add 7FFF+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        directedOp("sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        directedOp("sub 10-3-borrow", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 1);

        $display("[TB] reset during RUN");
        applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("mid-run reset OutValid", {31'd0, outValid}, 32'd0);
        checkOutput("mid-run reset Result", {16'd0, result}, 32'd0);
        checkOutput("mid-run reset InReady", {31'd0, inReady}, 32'd1);
        directedOp("add 1+1 after reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] WIDTH=4 instance");
        a4 = 4'h9;
        b4 = 4'h8;
        inValid4 = 1'b1;
        @(posedge clk); #1;
        inValid4 = 1'b0;
        @(posedge clk); #1;
        checkOutput("w4 OutValid", {31'd0, outValid4}, 32'd1);
        checkOutput("w4 Result", {28'd0, result4}, 32'h1);
        checkOutput("w4 carry/ovf/zero", {29'd0, carryOut4, overflow4, zero4}, {29'd0, 3'b110});

        $display("[TB] randomized operations");
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 7))
                0: a = 16'hFFFF;
                1: a = 16'h8000;
                2: a = 16'h7FFF;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: b = 16'h0001;
                1: b = a;
                2: b = 16'h8000;
                default: b = W'($urandom);
            endcase
            cin = 1'($urandom);
            sub = 1'($urandom);
            inValid = ($urandom_range(0, 2) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        outReady = 1'b1;
        repeat (NIB + 4) begin
            @(posedge clk); #1;
        end
        checkOutput("random ops completed >= 20", {31'd0, opsDone >= 20}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
